// File: rtl/riscv_regfile_wb.sv
// riscv_regfile_wb: write-back pipeline register, integer register file and load scoreboard
module riscv_regfile_wb #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter bit BYPASS = 1'b1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic [XLEN-1:0] rv1,
  output logic [XLEN-1:0] rv2,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [1:0]      wb_sel,
  input  logic [XLEN-1:0] regdata_R,
  input  logic [XLEN-1:0] regdata_I,
  input  logic [XLEN-1:0] load_data,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic            load_issue,
  input  logic [AW-1:0]   load_rd,
  output logic            hazard,
  output logic            err_ld
);
  logic [XLEN-1:0]  regs [NREGS];
  logic             wb_q_valid;
  logic [AW-1:0]    wb_q_rd;
  logic [XLEN-1:0]  wb_q_data;
  logic [XLEN-1:0]  wb_data;
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;
  logic             ld_ret;
  always_comb begin
    wb_data = wb_sel == 2'd0 ? regdata_R : wb_sel == 2'd1 ? regdata_I : wb_sel == 2'd2 ? load_data : pc_plus4;
    ld_ret = wb_valid && wb_sel == 2'd2;
    pend_nxt = pend;
    if (ld_ret) pend_nxt[wb_rd] = 1'b0;
    if (load_issue && load_rd != '0) pend_nxt[load_rd] = 1'b1;
    rv1 = rs1_addr == '0 ? '0 : (BYPASS && wb_q_valid && wb_q_rd == rs1_addr) ? wb_q_data : regs[rs1_addr];
    rv2 = rs2_addr == '0 ? '0 : (BYPASS && wb_q_valid && wb_q_rd == rs2_addr) ? wb_q_data : regs[rs2_addr];
    hazard = (rs1_used && pend[rs1_addr]) || (rs2_used && pend[rs2_addr]);
  end
  // the commit of the held result shares the edge that captures the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      wb_q_valid <= 1'b0;
      wb_q_rd <= '0;
      wb_q_data <= '0;
      pend <= '0;
      err_ld <= 1'b0;
    end else begin
      wb_q_valid <= wb_valid;
      if (wb_valid) begin
        wb_q_rd <= wb_rd;
        wb_q_data <= wb_data;
      end
      if (wb_q_valid && wb_q_rd != '0) regs[wb_q_rd] <= wb_q_data;
      pend <= pend_nxt;
      if (ld_ret && !pend[wb_rd] && wb_rd != '0) err_ld <= 1'b1;
    end
  end
endmodule

// File: tb/tb_riscv_regfile_wb.sv
// tb_riscv_regfile_wb: directed and random checks of riscv_regfile_wb against a visible-value model
module tb_riscv_regfile_wb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1_addr, rs2_addr, wb_rd, load_rd;
  logic        rs1_used, rs2_used, wb_valid, load_issue;
  logic [1:0]  wb_sel;
  logic [31:0] regdata_R, regdata_I, load_data, pc_plus4;
  logic [31:0] rv1, rv2;
  logic        hazard, err_ld;
  int          passed = 0;
  int          total = 0;
  bit          cmp_en = 1'b0;
  logic [31:0] vis [32];
  bit          m_pend [32];
  bit          m_err;

  riscv_regfile_wb dut (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rv1(rv1), .rv2(rv2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_sel(wb_sel), .regdata_R(regdata_R),
    .regdata_I(regdata_I), .load_data(load_data), .pc_plus4(pc_plus4),
    .load_issue(load_issue), .load_rd(load_rd), .hazard(hazard), .err_ld(err_ld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] sel_val();
    case (wb_sel)
      2'd0: return regdata_R;
      2'd1: return regdata_I;
      2'd2: return load_data;
      default: return pc_plus4;
    endcase
  endfunction

  // a result presented this cycle is simply what that register reads as from the next cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        vis[i] = '0;
        m_pend[i] = 1'b0;
      end
      m_err = 1'b0;
    end else begin
      if (wb_valid && wb_rd != 0) vis[wb_rd] = sel_val();
      if (wb_valid && wb_sel == 2 && wb_rd != 0 && !m_pend[wb_rd]) m_err = 1'b1;
      if (wb_valid && wb_sel == 2) m_pend[wb_rd] = 1'b0;
      if (load_issue && load_rd != 0) m_pend[load_rd] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rv1", rv1, rs1_addr == 0 ? 32'd0 : vis[rs1_addr]);
      chk("rv2", rv2, rs2_addr == 0 ? 32'd0 : vis[rs2_addr]);
      chk("hazard", {31'd0, hazard}, {31'd0, (rs1_used && m_pend[rs1_addr]) || (rs2_used && m_pend[rs2_addr])});
      chk("err_ld", {31'd0, err_ld}, {31'd0, m_err});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0;
    load_issue = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] v);
    wb_valid = 1'b1;
    wb_rd = rd;
    wb_sel = sel;
    regdata_R = sel == 0 ? v : $urandom;
    regdata_I = sel == 1 ? v : $urandom;
    load_data = sel == 2 ? v : $urandom;
    pc_plus4 = sel == 3 ? v : $urandom;
  endtask

  task automatic issue(input logic [4:0] rd);
    load_issue = 1'b1;
    load_rd = rd;
  endtask

  initial begin
    {rs1_addr, rs2_addr, wb_rd, load_rd, rs1_used, rs2_used, wb_valid, load_issue, wb_sel} = '0;
    {regdata_R, regdata_I, load_data, pc_plus4} = '0;
    repeat (2) tick();
    chk("rst_rv1", rv1, 32'd0);
    chk("rst_hazard", {31'd0, hazard}, 32'd0);
    chk("rst_err", {31'd0, err_ld}, 32'd0);
    #3 rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();
    // T1
    rs1_addr = 5;
    wb(5, 0, 32'hDEADBEEF);
    tick(); idle();
    chk("t1_bypass", rv1, 32'hDEADBEEF);
    tick();
    chk("t1_array", rv1, 32'hDEADBEEF);
    // T2
    rs1_addr = 0; rs2_addr = 0;
    wb(0, 3, 32'h104);
    tick(); idle();
    chk("t2_rv1", rv1, 32'd0);
    chk("t2_rv2", rv2, 32'd0);
    tick();
    chk("t2_rv1_later", rv1, 32'd0);
    // T3
    rs1_addr = 3;
    wb(3, 0, 32'h1);
    tick();
    wb(3, 0, 32'h2);
    chk("t3_cyc1", rv1, 32'h1);
    tick(); idle();
    chk("t3_cyc2", rv1, 32'h2);
    tick();
    chk("t3_cyc3", rv1, 32'h2);
    // T4
    rs2_addr = 7; rs2_used = 1'b1;
    issue(7);
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      chk("t4_hazard_wait", {31'd0, hazard}, 32'd1);
      tick();
    end
    rs2_used = 1'b0;
    #1 chk("t4_unused", {31'd0, hazard}, 32'd0);
    rs2_used = 1'b1;
    wb(7, 2, 32'h55);
    tick(); idle();
    chk("t4_hazard_drop", {31'd0, hazard}, 32'd0);
    chk("t4_rv2", rv2, 32'h55);
    chk("t4_no_err", {31'd0, err_ld}, 32'd0);
    // T5
    rs2_used = 1'b0; rs1_addr = 9; rs1_used = 1'b1;
    issue(9);
    tick();
    wb(9, 2, 32'h99);
    tick(); idle();
    chk("t5_set_wins", {31'd0, hazard}, 32'd1);
    rs1_used = 1'b0; rs1_addr = 4;
    wb(4, 2, 32'h44);
    tick(); idle();
    chk("t5_err", {31'd0, err_ld}, 32'd1);
    chk("t5_reg4", rv1, 32'h44);
    wb(9, 2, 32'h9A);
    tick(); idle();
    chk("t5_err_sticky", {31'd0, err_ld}, 32'd1);
    // random traffic, addresses folded to 0..15 to force collisions
    for (int n = 0; n < 1500; n++) begin
      rs1_addr = 5'($urandom_range(0, 15));
      rs2_addr = 5'($urandom_range(0, 15));
      rs1_used = 1'($urandom);
      rs2_used = 1'($urandom);
      if ($urandom_range(0, 3) != 0) wb(5'($urandom_range(0, 15)), 2'($urandom), $urandom);
      else wb_valid = 1'b0;
      load_issue = $urandom_range(0, 3) == 0;
      load_rd = 5'($urandom_range(0, 15));
      tick();
    end
    idle();
    // T6
    rs2_addr = 10; rs2_used = 1'b1;
    issue(10);
    tick(); idle();
    rs1_addr = 6;
    wb(6, 0, 32'h66);
    tick(); idle();
    chk("t6_pre_rv1", rv1, 32'h66);
    chk("t6_pre_hazard", {31'd0, hazard}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rv1", rv1, 32'd0);
    chk("t6_hazard", {31'd0, hazard}, 32'd0);
    chk("t6_err", {31'd0, err_ld}, 32'd0);
    tick();
    #3 rst_n = 1'b1;
    tick();
    chk("t6_no_commit", rv1, 32'd0);
    tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
